// File: rtl/bus_xfer_ctrl.sv
// Transceiver sequencer: setup/strobe/hold phases per byte,
// with a dead turnaround whenever the bus direction flips.
module bus_xfer_ctrl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] bus_dout,
  output logic       bus_drv,
  input  logic [7:0] bus_din,
  output logic       buf_dir,
  output logic       buf_oe,
  output logic       buf_sel
);

  typedef enum logic [2:0] {
    IDLE, TURN1, TURN2, SETUP, STROBE, HOLD, RESP
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0] bus_dout_q, bus_dout_d;
  logic       bus_drv_q, bus_drv_d;
  logic       buf_dir_q, buf_dir_d;
  logic       buf_oe_q, buf_oe_d;
  logic       buf_sel_q, buf_sel_d;
  logic       done;
  logic       phase;

  assign done = (cnt_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          wdata_d = req_wdata;
          state_d = (req_wr == buf_dir_q) ? SETUP : TURN1;
        end
      end
      TURN1: state_d = TURN2;
      TURN2: if (done) state_d = SETUP;
      SETUP: if (done) state_d = STROBE;
      STROBE: begin
        if (done) begin
          state_d = HOLD;
          if (!wr_q) rsp_rdata_d = bus_din;
        end
      end
      HOLD: if (done) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = done ? cnt_q : cnt_q - 8'd1;
    if (state_d != state_q) begin
      unique case (1'b1)
        state_d == TURN2:  cnt_d = TURN_LD;
        state_d == SETUP:  cnt_d = SETUP_LD;
        state_d == STROBE: cnt_d = STROBE_LD;
        state_d == HOLD:   cnt_d = HOLD_LD;
        default:           cnt_d = 8'd0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered
  // and line up with the state they belong to.
  always_comb begin
    phase       = (state_d == SETUP) || (state_d == STROBE)
               || (state_d == HOLD);
    buf_sel_d   = phase;
    buf_oe_d    = (state_d == STROBE);
    bus_drv_d   = phase && wr_d;
    rsp_valid_d = (state_d == RESP);
    buf_dir_d   = buf_dir_q;
    bus_dout_d  = bus_dout_q;
    if (state_d == TURN2) buf_dir_d = wr_d;
    if (phase && wr_d) bus_dout_d = wdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      bus_dout_q  <= 8'h00;
      bus_drv_q   <= 1'b0;
      buf_dir_q   <= 1'b0;
      buf_oe_q    <= 1'b0;
      buf_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_dout_q  <= bus_dout_d;
      bus_drv_q   <= bus_drv_d;
      buf_dir_q   <= buf_dir_d;
      buf_oe_q    <= buf_oe_d;
      buf_sel_q   <= buf_sel_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_dout  = bus_dout_q;
  assign bus_drv   = bus_drv_q;
  assign buf_dir   = buf_dir_q;
  assign buf_oe    = buf_oe_q;
  assign buf_sel   = buf_sel_q;

endmodule
